writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Writeback stage of the 32-bit pipelined MIPS core: the writer side of the register-file write port that the decode stage exposes as `RegWrite`/`WriteReg`/`WriteData`. It registers the MEM/WB result and selects between ALU and memory data. It shares the single write port with the multi-cycle Booth multiplier through a small result FIFO. It also reports pending multiplier destinations to the hazard unit so that decode does not read stale operands.

## Interface
Parameters:
- `DEPTH`, 2 – multiplier result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4 – number of consecutive cycles a FIFO head may wait before `wb_stall` is raised.

Ports:
- `clk` in 1 – single clock; all state updates on the rising edge.
- `rst` in 1 – synchronous, active-high reset.
- `mem_valid` in 1 – MEM/WB slot carries an instruction.
- `mem_reg_write` in 1 – the instruction writes a register.
- `mem_to_reg` in 1 – 1 selects `mem_read_data`, 0 selects `mem_alu_result`.
- `mem_write_reg` in 5 – destination register.
- `mem_alu_result` in 32 – ALU result.
- `mem_read_data` in 32 – load data.
- `mul_valid` in 1 – multiplier offers a result.
- `mul_ready` out 1 – FIFO accepts; the transfer occurs when `mul_valid & mul_ready`.
- `mul_dest` in 5 – multiplier destination register.
- `mul_result` in 32 – low product word.
- `rs`, `rt` in 5 each – decode source registers.
- `pend_rs_hit`, `pend_rt_hit` out 1 each – a source register matches a pending FIFO destination.
- `wb_stall` out 1 – upstream must present `mem_valid=0` next cycle.
- `RegWrite` out 1, `WriteReg` out 5, `WriteData` out 32 – register-file write port.

## Operation
- **Pipeline write**
  - A pipeline write is `mem_valid & mem_reg_write & (mem_write_reg != 0)`.
  - It always wins the port.
  - It is registered into `RegWrite=1`, `WriteReg`, and `WriteData` (selected by `mem_to_reg`).
- **FIFO drain**
  - When no pipeline write occurs and the FIFO is non-empty, the head is popped.
  - A valid head drives the write port.
  - A squashed head drives `RegWrite=0`.
- **Idle cycle:** otherwise `RegWrite=0`. `WriteReg`/`WriteData` hold their previous values.
- **Multiplier push**
  - `mul_ready = (count < DEPTH) & ~rst`.
  - An accepted push with `mul_dest=0` is stored squashed.
  - All multiplier results go through the FIFO; there is no bypass.
- **WAW squash**
  - When a pipeline write to R is accepted, every FIFO entry with destination R is squashed, because the pipeline instruction is younger.
  - An entry pushed in that same cycle to R is also squashed.
- **Hazard report**
  - `pend_rs_hit = (rs != 0) & ∃ valid, non-squashed entry with dest == rs`.
  - `pend_rt_hit` is the same check for `rt`.
  - Both are combinational on the current FIFO contents.
- **Starvation counter**
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - `wb_stall` is registered and asserts on the cycle after the counter reaches `STARVE_LIMIT`.
  - It stays high until a pop occurs.
  - Upstream guarantees `mem_valid=0` in every cycle `wb_stall=1`, so the drain happens that cycle.
- **Simultaneous push and pop when full:** ready is computed from the pre-edge count, so no push is accepted. A pop and push in the same cycle at `count<DEPTH` is legal.

## Timing
- **Reset values:** `RegWrite=0`, `WriteReg=0`, `WriteData=0`, `wb_stall=0`, `mul_ready=0`, hit outputs 0. The FIFO is empty and the counter is 0.
- **Reset mid-operation:** pending FIFO entries are discarded.
- **Pipeline latency:** 1 cycle from sampled MEM/WB inputs to the write-port outputs.
- **Multiplier latency:** at least 2 cycles from accepted push to the write port (push edge, then pop edge).
- **`mul_ready`:** rises in the first cycle after `rst` deasserts.
- **FIFO wrap-around:** read and write pointers wrap modulo `DEPTH`. Full and empty are distinguished by the count.

## Structure
- **Shared package `mips_pkg`:** `REG_W=5`, `DATA_W=32`, and `wb_entry_t` (`dest[4:0]`, `data[31:0]`, `live`).
- **Sub-module `wb_mul_fifo`:**
  - Circular buffer with a per-entry `live` bit.
  - Squash-by-destination input.
  - Combinational match outputs for `rs`/`rt`.
- **Top level:** MEM/WB register, port arbitration, starvation counter.

## Test plan
1. **Reset and release:** hold `rst` 3 cycles → all outputs 0 and `mul_ready=0`; `mul_ready=1` in the first cycle after release.
2. **ALU write:** `mem_valid=1`, `mem_reg_write=1`, dest 5, `mem_to_reg=0`, ALU 0x00001234 → next cycle `RegWrite=1`, `WriteReg=5`, `WriteData=0x00001234`.
3. **Load and $0 writes:** same as scenario 2 but `mem_to_reg=1` with load data 0xCAFEBABE → `WriteData=0xCAFEBABE`; dest 0 → `RegWrite=0`.
4. **Multiplier drain:** push dest 8, 0xFFFFFFF0 while the pipeline is idle → `pend_rs_hit=1` for `rs=8` on the next cycle; `RegWrite=1`, `WriteReg=8` two cycles after the push; hit clears after the pop.
5. **Starvation:**
   - Push 2 entries while the pipeline writes every cycle → `mul_ready=0` after the second push.
   - `wb_stall=1` after 4 starved cycles.
   - With `mem_valid=0`, the head drains and `wb_stall` drops.
6. **WAW squash:** pending dest 9 = 0x11111111, pipeline write to 9 = 0x22222222 → 9 is written with 0x22222222 only; the drained entry gives `RegWrite=0`; `pend_rt_hit` for `rt=9` clears immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and the multiplier writeback entry type.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // live=0 marks an entry that still occupies a slot but must not write the register file
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - MEM/WB, multiplier, hazard and register-file port bundle.
interface writeback_arbiter_if;
  import mips_pkg::*;

  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_to_reg;
  logic [REG_W-1:0]  mem_write_reg;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;

  logic              mul_valid;
  logic              mul_ready;
  logic [REG_W-1:0]  mul_dest;
  logic [DATA_W-1:0] mul_result;

  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic              pend_rs_hit;
  logic              pend_rt_hit;
  logic              wb_stall;

  logic              RegWrite;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output mem_valid, mem_reg_write, mem_to_reg, mem_write_reg, mem_alu_result, mem_read_data,
    output mul_valid, mul_dest, mul_result, rs, rt,
    input  mul_ready, pend_rs_hit, pend_rt_hit, wb_stall, RegWrite, WriteReg, WriteData
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_to_reg, mem_write_reg, mem_alu_result, mem_read_data,
    input  mul_valid, mul_dest, mul_result, rs, rt,
    output mul_ready, pend_rs_hit, pend_rt_hit, wb_stall, RegWrite, WriteReg, WriteData
  );

endinterface

// File: rtl/wb_mul_fifo.sv
// rtl/wb_mul_fifo.sv - multiplier result FIFO with destination squash and hazard match.
module wb_mul_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  input  logic             i_squash_en,
  input  logic [REG_W-1:0] i_squash_dest,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_rs_hit,
  output logic             o_rt_hit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // Popped slots drop live, so live alone identifies pending, still-valid results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_squash_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].dest == i_squash_dest) begin
            r_mem[i].live <= 1'b0;
          end
        end
      end
      if (i_pop) begin
        r_mem[r_rd_ptr].live <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_rs_hit = 1'b0;
    o_rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live && (r_mem[i].dest == i_rs)) o_rs_hit = 1'b1;
      if (r_mem[i].live && (r_mem[i].dest == i_rt)) o_rt_hit = 1'b1;
    end
    if (i_rs == '0) o_rs_hit = 1'b0;
    if (i_rt == '0) o_rt_hit = 1'b0;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - MEM/WB register, write-port arbitration and starvation guard.
module writeback_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic              w_pipe_wr;
  logic              w_pop;
  logic              w_push;
  logic              w_ready;
  logic              w_full;
  logic              w_empty;
  logic              w_rs_hit;
  logic              w_rt_hit;
  wb_entry_t         w_head;
  wb_entry_t         w_push_entry;
  logic [SW-1:0]     w_starve_next;

  logic              r_reg_write;
  logic [REG_W-1:0]  r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [SW-1:0]     r_starve;
  logic              r_stall;

  assign w_pipe_wr = bus.mem_valid & bus.mem_reg_write & (bus.mem_write_reg != '0);
  assign w_pop     = ~w_pipe_wr & ~w_empty;
  assign w_ready   = ~w_full & ~rst;
  assign w_push    = bus.mul_valid & w_ready;

  // A same-cycle pipeline write to the same register is younger, so the new entry is born dead
  always_comb begin
    w_push_entry.dest = bus.mul_dest;
    w_push_entry.data = bus.mul_result;
    w_push_entry.live = (bus.mul_dest != '0) &
                        ~(w_pipe_wr & (bus.mul_dest == bus.mem_write_reg));
  end

  wb_mul_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_entry  (w_push_entry),
    .i_pop         (w_pop),
    .i_squash_en   (w_pipe_wr),
    .i_squash_dest (bus.mem_write_reg),
    .i_rs          (bus.rs),
    .i_rt          (bus.rt),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_rs_hit      (w_rs_hit),
    .o_rt_hit      (w_rt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_pipe_wr) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= bus.mem_write_reg;
      r_write_data <= bus.mem_to_reg ? bus.mem_read_data : bus.mem_alu_result;
    end else if (w_pop) begin
      r_reg_write <= w_head.live;
      if (w_head.live) begin
        r_write_reg  <= w_head.dest;
        r_write_data <= w_head.data;
      end
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  always_comb begin
    w_starve_next = '0;
    if (~w_empty & ~w_pop) begin
      w_starve_next = (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);
    end
  end

  // Stall latches once the head has waited the limit and is released only by a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      r_stall  <= ~w_pop & (r_stall | (w_starve_next >= SW'(STARVE_LIMIT)));
    end
  end

  assign bus.mul_ready   = w_ready;
  assign bus.pend_rs_hit = w_rs_hit;
  assign bus.pend_rt_hit = w_rt_hit;
  assign bus.wb_stall    = r_stall;
  assign bus.RegWrite    = r_reg_write;
  assign bus.WriteReg    = r_write_reg;
  assign bus.WriteData   = r_write_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter with a queue model.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    bit          live;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ent_t        q[$];
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_starve;
  logic        m_stall;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].dest == r) return 1'b1;
    return 1'b0;
  endfunction

  // Applies one cycle of inputs, advances the model by the behavioural rules, returns at the negedge
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic mv, input logic [4:0] md, input logic [31:0] mr);
    bit   pipe, push, pop;
    int   pre_n;
    ent_t e;
    bus.mem_valid = v; bus.mem_reg_write = rw; bus.mem_to_reg = m2r; bus.mem_write_reg = wr;
    bus.mem_alu_result = alu; bus.mem_read_data = ld;
    bus.mul_valid = mv; bus.mul_dest = md; bus.mul_result = mr;
    if (rst) begin
      q.delete();
      m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_starve = 0; m_stall = 1'b0;
    end else begin
      pipe  = v && rw && (wr != 5'd0);
      push  = mv && (q.size() < DEPTH);
      pop   = 1'b0;
      pre_n = q.size();
      if (pipe) begin
        m_rw = 1'b1; m_wreg = wr; m_wdata = m2r ? ld : alu;
        foreach (q[i]) if (q[i].dest == wr) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        pop = 1'b1;
        m_rw = e.live;
        if (e.live) begin m_wreg = e.dest; m_wdata = e.data; end
      end else begin
        m_rw = 1'b0;
      end
      if (push) begin
        e.dest = md; e.data = mr; e.live = (md != 5'd0) && !(pipe && md == wr);
        q.push_back(e);
      end
      if (pre_n > 0 && !pop) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
      m_stall = !pop && (m_stall || m_starve >= LIMIT);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rs = 5'd8; bus.rt = 5'd9;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", bus.RegWrite); end
    checks++; if (bus.WriteReg !== 5'd0) begin failures++; $display("FAIL reset_writereg got=%0d exp=0", bus.WriteReg); end
    checks++; if (bus.WriteData !== 32'd0) begin failures++; $display("FAIL reset_writedata got=%h exp=0", bus.WriteData); end
    checks++; if (bus.wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.wb_stall); end
    checks++; if (bus.mul_ready !== 1'b0) begin failures++; $display("FAIL reset_mul_ready got=%0b exp=0", bus.mul_ready); end
    checks++; if ({bus.pend_rs_hit, bus.pend_rt_hit} !== 2'b00) begin failures++; $display("FAIL reset_hits got=%b exp=00", {bus.pend_rs_hit, bus.pend_rt_hit}); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mul_ready !== 1'b1) begin failures++; $display("FAIL release_mul_ready got=%0b exp=1", bus.mul_ready); end
  endtask

  task automatic test_alu_write();
    drive(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL alu_regwrite got=%0b exp=1", bus.RegWrite); end
    checks++; if (bus.WriteReg !== 5'd5) begin failures++; $display("FAIL alu_writereg got=%0d exp=5", bus.WriteReg); end
    checks++; if (bus.WriteData !== 32'h0000_1234) begin failures++; $display("FAIL alu_writedata got=%h exp=00001234", bus.WriteData); end
  endtask

  task automatic test_load_zero();
    drive(1, 1, 1, 5'd5, 32'h0000_1234, 32'hCAFE_BABE, 0, 0, 0);
    checks++; if (bus.WriteData !== 32'hCAFE_BABE) begin failures++; $display("FAIL load_writedata got=%h exp=cafebabe", bus.WriteData); end
    drive(1, 1, 0, 5'd0, 32'h5555_5555, 32'h0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL zero_dest_regwrite got=%0b exp=0", bus.RegWrite); end
    checks++; if (bus.WriteData !== 32'hCAFE_BABE) begin failures++; $display("FAIL zero_dest_hold got=%h exp=cafebabe", bus.WriteData); end
  endtask

  task automatic test_mul_drain();
    bus.rs = 5'd8;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd8, 32'hFFFF_FFF0);
    checks++; if (bus.pend_rs_hit !== 1'b1) begin failures++; $display("FAIL drain_hit_pending got=%0b exp=1", bus.pend_rs_hit); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL drain_not_yet got=%0b exp=0", bus.RegWrite); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd8) begin failures++; $display("FAIL drain_write got=%0b/%0d exp=1/8", bus.RegWrite, bus.WriteReg); end
    checks++; if (bus.WriteData !== 32'hFFFF_FFF0) begin failures++; $display("FAIL drain_data got=%h exp=fffffff0", bus.WriteData); end
    checks++; if (bus.pend_rs_hit !== 1'b0) begin failures++; $display("FAIL drain_hit_clear got=%0b exp=0", bus.pend_rs_hit); end
  endtask

  task automatic test_starvation();
    drive(1, 1, 0, 5'd3, 32'h1, 0, 1, 5'd10, 32'hA0A0_A0A0);
    drive(1, 1, 0, 5'd3, 32'h2, 0, 1, 5'd11, 32'hB0B0_B0B0);
    bus.mul_valid = 1'b0;
    #1;
    checks++; if (bus.mul_ready !== 1'b0) begin failures++; $display("FAIL starve_full_ready got=%0b exp=0", bus.mul_ready); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 5'd3, 32'h3 + i, 0, 0, 0, 0);
      checks++; if (bus.wb_stall !== 1'b0) begin failures++; $display("FAIL starve_early_stall[%0d] got=%0b exp=0", i, bus.wb_stall); end
    end
    drive(1, 1, 0, 5'd3, 32'h7, 0, 0, 0, 0);
    checks++; if (bus.wb_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0b exp=1", bus.wb_stall); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd10) begin failures++; $display("FAIL starve_drain got=%0b/%0d exp=1/10", bus.RegWrite, bus.WriteReg); end
    checks++; if (bus.wb_stall !== 1'b0) begin failures++; $display("FAIL starve_release got=%0b exp=0", bus.wb_stall); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.WriteReg !== 5'd11 || bus.WriteData !== 32'hB0B0_B0B0) begin failures++; $display("FAIL starve_second got=%0d/%h exp=11/b0b0b0b0", bus.WriteReg, bus.WriteData); end
  endtask

  task automatic test_waw_squash();
    bus.rt = 5'd9;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h1111_1111);
    checks++; if (bus.pend_rt_hit !== 1'b1) begin failures++; $display("FAIL waw_hit_pending got=%0b exp=1", bus.pend_rt_hit); end
    drive(1, 1, 0, 5'd9, 32'h2222_2222, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd9 || bus.WriteData !== 32'h2222_2222) begin failures++; $display("FAIL waw_pipe got=%0b/%0d/%h exp=1/9/22222222", bus.RegWrite, bus.WriteReg, bus.WriteData); end
    checks++; if (bus.pend_rt_hit !== 1'b0) begin failures++; $display("FAIL waw_hit_clear got=%0b exp=0", bus.pend_rt_hit); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL waw_squashed_pop got=%0b exp=0", bus.RegWrite); end
    checks++; if (bus.WriteData !== 32'h2222_2222) begin failures++; $display("FAIL waw_hold got=%h exp=22222222", bus.WriteData); end
  endtask

  task automatic test_reset_mid();
    bus.rs = 5'd12;
    drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hDEAD_0012);
    checks++; if (bus.pend_rs_hit !== 1'b1) begin failures++; $display("FAIL midrst_pending got=%0b exp=1", bus.pend_rs_hit); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checks++; if (bus.pend_rs_hit !== 1'b0) begin failures++; $display("FAIL midrst_hit got=%0b exp=0", bus.pend_rs_hit); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_no_drain got=%0b exp=0", bus.RegWrite); end
  endtask

  task automatic test_random();
    logic [4:0] regs [5];
    logic       v, rw, m2r, mv;
    logic [4:0] wr, md;
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10; regs[4] = 5'd11;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 1) == 1) && !m_stall;
      rw  = ($urandom_range(0, 3) != 0);
      m2r = $urandom_range(0, 1);
      wr  = regs[$urandom_range(0, 4)];
      mv  = $urandom_range(0, 1);
      md  = regs[$urandom_range(0, 4)];
      bus.rs = regs[$urandom_range(0, 4)];
      bus.rt = regs[$urandom_range(0, 4)];
      bus.mul_valid = mv;
      #1;
      checks++; if (bus.mul_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", n, bus.mul_ready, q.size() < DEPTH); end
      checks++; if (bus.pend_rs_hit !== model_hit(bus.rs) || bus.pend_rt_hit !== model_hit(bus.rt)) begin failures++; $display("FAIL rnd_hits[%0d] got=%b exp=%b", n, {bus.pend_rs_hit, bus.pend_rt_hit}, {model_hit(bus.rs), model_hit(bus.rt)}); end
      drive(v, rw, m2r, wr, $urandom, $urandom, mv, md, $urandom);
      checks++; if (bus.RegWrite !== m_rw || bus.WriteReg !== m_wreg || bus.WriteData !== m_wdata) begin failures++; $display("FAIL rnd_port[%0d] got=%0b/%0d/%h exp=%0b/%0d/%h", n, bus.RegWrite, bus.WriteReg, bus.WriteData, m_rw, m_wreg, m_wdata); end
      checks++; if (bus.wb_stall !== m_stall) begin failures++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", n, bus.wb_stall, m_stall); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_to_reg = 0; bus.mem_write_reg = 0;
    bus.mem_alu_result = 0; bus.mem_read_data = 0;
    bus.mul_valid = 0; bus.mul_dest = 0; bus.mul_result = 0; bus.rs = 0; bus.rt = 0;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_load_zero();
    test_mul_drain();
    test_starvation();
    test_waw_squash();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
